// File: rtl/fetch_unit_if.sv
// fetch_unit_if: instruction memory req/ack read bus between the fetch stage and memory
interface fetch_unit_if;
  logic        req;
  logic [31:0] addr;
  logic        ack;
  logic [31:0] rdata;
  modport master (output req, addr, input ack, rdata);
  modport slave (input req, addr, output ack, rdata);
endinterface

// File: rtl/fetch_unit.sv
// fetch_unit: holds the PC, fetches one word per instruction over req/ack and commits it to the decoder
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          TIMEOUT  = 16
) (
  input  logic          i_clk,
  input  logic          i_rst,
  input  logic          i_stall,
  input  logic          i_Jump,
  input  logic          i_Branch,
  input  logic          i_Bne,
  input  logic          i_zero,
  input  logic [31:0]   i_imm,
  fetch_unit_if.master  io_imem,
  output logic [31:0]   o_instruction,
  output logic          o_valid,
  output logic [31:0]   o_pc,
  output logic [31:0]   o_pc_plus4,
  output logic [31:0]   o_retired,
  output logic          o_fault
);
  localparam int CW = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
  typedef enum logic [1:0] {IDLE, FETCH, EXEC, FAULT} state_t;
  state_t          r_state, w_next;
  logic [CW-1:0]   r_wait;
  logic [31:0]     r_pc, r_instr, r_retired, w_next_pc;
  logic            w_ack, w_expire, w_taken;
  assign w_ack    = (r_state == FETCH) && io_imem.ack;
  assign w_expire = (r_state == FETCH) && !io_imem.ack && (r_wait == CW'(TIMEOUT - 1));
  assign w_taken  = i_Branch && (i_Bne ? !i_zero : i_zero);
  always_comb begin
    o_valid    = (r_state == EXEC) && !i_stall;
    o_pc_plus4 = r_pc + 32'd4;
    w_next_pc  = i_Jump ? {o_pc_plus4[31:28], r_instr[25:0], 2'b00} :
                 w_taken ? o_pc_plus4 + {i_imm[29:0], 2'b00} : o_pc_plus4;
    w_next     = (r_state == IDLE) ? FETCH :
                 w_ack ? EXEC :
                 w_expire ? FAULT :
                 o_valid ? FETCH : r_state;
  end
  // wait counter runs only while in FETCH, so it is zero on every FETCH entry
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_state   <= IDLE;
      r_wait    <= '0;
      r_pc      <= RESET_PC;
      r_instr   <= '0;
      r_retired <= '0;
    end else begin
      r_state <= w_next;
      r_wait  <= (r_state == FETCH) ? r_wait + 1'b1 : '0;
      if (w_ack) r_instr <= io_imem.rdata;
      if (o_valid) begin
        r_pc      <= w_next_pc;
        r_retired <= r_retired + 32'd1;
      end
    end
  end
  assign io_imem.req   = (r_state == FETCH);
  assign io_imem.addr  = r_pc;
  assign o_pc          = r_pc;
  assign o_instruction = r_instr;
  assign o_retired     = r_retired;
  assign o_fault       = (r_state == FAULT);
endmodule

// File: tb/tb_fetch_unit.sv
// tb_fetch_unit: table-driven and randomized checks of fetch_unit against an arithmetic next-PC model
module tb_fetch_unit;
  logic        clk = 0;
  logic        rst, stall, jump, branch, bne, zero;
  logic [31:0] imm, instruction, pc, pc_plus4, retired;
  logic        valid, fault;
  int          n_pass = 0, n_total = 0;
  logic [31:0] exp_pc = 0, exp_ret = 0;

  fetch_unit_if bus ();

  fetch_unit #(.RESET_PC(32'h0), .TIMEOUT(4)) dut (
    .i_clk(clk), .i_rst(rst), .i_stall(stall), .i_Jump(jump), .i_Branch(branch),
    .i_Bne(bne), .i_zero(zero), .i_imm(imm), .io_imem(bus.master),
    .o_instruction(instruction), .o_valid(valid), .o_pc(pc), .o_pc_plus4(pc_plus4),
    .o_retired(retired), .o_fault(fault)
  );

  always #5 clk = ~clk;

  typedef struct {
    int          waits, stalls;
    logic        j, b, n, z;
    logic [31:0] imm, instr, exp_next;
  } vec_t;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", name, act, exp);
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_next(input logic [31:0] cur, instr, input logic j, b, n, z,
                                           input logic [31:0] im);
    logic [31:0] seq;
    seq = cur + 32'd4;
    if (j) return (seq & 32'hF000_0000) | ((instr & 32'h03FF_FFFF) * 4);
    if (b && (n ? !z : z)) return seq + im * 4;
    return seq;
  endfunction

  // Starts at posedge+1 in FETCH; ends at posedge+1 back in FETCH after the commit.
  task automatic run_instr(input int waits, stalls, input logic j, b, n, z,
                           input logic [31:0] im, instr, exp_next);
    for (int w = 0; w < waits; w++) begin
      bus.ack = 0;
      bus.rdata = $urandom;
      #1;
      check("req_wait", {31'b0, bus.req}, 1);
      check("addr_wait", bus.addr, exp_pc);
      check("valid_wait", {31'b0, valid}, 0);
      tick();
    end
    bus.ack = 1;
    bus.rdata = instr;
    #1;
    check("req_ack", {31'b0, bus.req}, 1);
    check("addr_ack", bus.addr, exp_pc);
    tick();
    bus.ack = 0;
    bus.rdata = $urandom;
    check("instr", instruction, instr);
    for (int s = 0; s < stalls; s++) begin
      stall = 1;
      jump = j; branch = b; bne = n; zero = z; imm = im;
      #1;
      check("valid_stall", {31'b0, valid}, 0);
      check("pc_stall", pc, exp_pc);
      check("ret_stall", retired, exp_ret);
      tick();
    end
    stall = 0;
    jump = j; branch = b; bne = n; zero = z; imm = im;
    #1;
    check("valid_commit", {31'b0, valid}, 1);
    check("instr_hold", instruction, instr);
    check("pc_plus4", pc_plus4, exp_pc + 32'd4);
    tick();
    jump = 0; branch = 0; bne = 0; zero = 0; imm = 0;
    check("next_pc", pc, exp_next);
    check("retired", retired, exp_ret + 32'd1);
    check("valid_after", {31'b0, valid}, 0);
    exp_pc = exp_next;
    exp_ret = exp_ret + 32'd1;
  endtask

  initial begin
    vec_t vecs[15];
    vecs[0]  = '{0, 0, 0, 0, 0, 0, 32'h0,         32'h2008_0005, 32'h0000_0004};
    vecs[1]  = '{0, 0, 0, 0, 0, 0, 32'h0,         32'h2008_0005, 32'h0000_0008};
    vecs[2]  = '{3, 0, 0, 0, 0, 0, 32'h0,         32'h2008_0005, 32'h0000_000C};
    vecs[3]  = '{1, 3, 0, 0, 0, 0, 32'h0,         32'h1234_5678, 32'h0000_0010};
    vecs[4]  = '{0, 0, 0, 1, 0, 1, 32'hFFFF_FFFE, 32'h1000_FFFE, 32'h0000_000C};
    vecs[5]  = '{0, 0, 0, 0, 0, 0, 32'h0,         32'h2008_0005, 32'h0000_0010};
    vecs[6]  = '{0, 0, 0, 1, 0, 0, 32'hFFFF_FFFE, 32'h1000_FFFE, 32'h0000_0014};
    vecs[7]  = '{2, 0, 0, 1, 0, 1, 32'hFFFF_FFFE, 32'h1000_FFFE, 32'h0000_0010};
    vecs[8]  = '{0, 1, 0, 1, 1, 0, 32'hFFFF_FFFE, 32'h1400_FFFE, 32'h0000_000C};
    vecs[9]  = '{0, 0, 0, 1, 1, 1, 32'hFFFF_FFFE, 32'h1400_FFFE, 32'h0000_0010};
    vecs[10] = '{0, 0, 0, 1, 0, 1, 32'h3BFF_FFFD, 32'hABCD_0000, 32'hF000_0008};
    vecs[11] = '{0, 0, 1, 0, 0, 0, 32'h0,         32'h0800_0040, 32'hF000_0100};
    vecs[12] = '{1, 2, 0, 1, 0, 1, 32'hFFFF_FFC1, 32'h1000_FFC1, 32'hF000_0008};
    vecs[13] = '{0, 0, 1, 1, 0, 1, 32'h0000_0005, 32'h0C00_0040, 32'hF000_0100};
    vecs[14] = '{0, 0, 1, 0, 0, 0, 32'h0,         32'hFC00_0000, 32'hF000_0000};
    rst = 1; stall = 0; jump = 0; branch = 0; bne = 0; zero = 0; imm = 0;
    bus.ack = 0; bus.rdata = 0;
    #3;
    repeat (2) tick();
    check("rst_pc", pc, 32'h0);
    check("rst_instr", instruction, 32'h0);
    check("rst_retired", retired, 32'h0);
    check("rst_fault", {31'b0, fault}, 0);
    check("rst_valid", {31'b0, valid}, 0);
    check("rst_req", {31'b0, bus.req}, 0);
    rst = 0;
    bus.ack = 1;
    bus.rdata = 32'hDEAD_0000;
    #1;
    check("idle_req", {31'b0, bus.req}, 0);
    tick();
    check("idle_ack_ignored", instruction, 32'h0);
    bus.ack = 0;
    foreach (vecs[i])
      run_instr(vecs[i].waits, vecs[i].stalls, vecs[i].j, vecs[i].b, vecs[i].n, vecs[i].z,
                vecs[i].imm, vecs[i].instr, vecs[i].exp_next);
    check("pc_tail", pc, 32'hF000_0000);
    run_instr(0, 0, 0, 1, 0, 1, 32'h0400_0000, 32'h1000_0000, 32'h0000_0004);
    for (int k = 0; k < 40; k++) begin
      logic        j, b, n, z;
      logic [31:0] im, ins;
      j = ($urandom_range(0, 5) == 0);
      b = 1'($urandom);
      n = 1'($urandom);
      z = 1'($urandom);
      im = 32'($urandom_range(0, 31)) - 32'd16;
      ins = $urandom;
      run_instr($urandom_range(0, 3), $urandom_range(0, 2), j, b, n, z, im, ins,
                ref_next(exp_pc, ins, j, b, n, z, im));
    end
    for (int c = 0; c < 4; c++) begin
      bus.ack = 0;
      #1;
      check("to_req", {31'b0, bus.req}, 1);
      check("to_fault_pre", {31'b0, fault}, 0);
      tick();
    end
    check("to_fault", {31'b0, fault}, 1);
    check("to_req_off", {31'b0, bus.req}, 0);
    check("to_valid", {31'b0, valid}, 0);
    bus.ack = 1;
    repeat (3) tick();
    check("to_sticky", {31'b0, fault}, 1);
    check("to_pc_hold", pc, exp_pc);
    check("to_ret_hold", retired, exp_ret);
    bus.ack = 0;
    rst = 1;
    #1;
    check("async_rst_fault", {31'b0, fault}, 0);
    check("async_rst_pc", pc, 32'h0);
    tick();
    rst = 0;
    exp_pc = 0;
    exp_ret = 0;
    tick();
    run_instr(0, 0, 0, 0, 0, 0, 32'h0, 32'h2008_0005, 32'h0000_0004);
    bus.ack = 1;
    bus.rdata = 32'hDEAD_BEEF;
    #1;
    rst = 1;
    #1;
    check("mid_pc", pc, 32'h0);
    check("mid_instr", instruction, 32'h0);
    check("mid_retired", retired, 32'h0);
    check("mid_valid", {31'b0, valid}, 0);
    check("mid_req", {31'b0, bus.req}, 0);
    tick();
    check("mid_instr_edge", instruction, 32'h0);
    rst = 0;
    bus.ack = 0;
    tick();
    check("mid_refetch_req", {31'b0, bus.req}, 1);
    check("mid_refetch_addr", bus.addr, 32'h0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end
endmodule
